// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared types for the iterative mul/div sequencer.
// Op and state encodings plus the datapath width.
package muldiv_pkg;
  localparam int WIDTH = 32;
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    MUL   = 2'b00,
    MULHU = 2'b01,
    UDIV  = 2'b10,
    SDIV  = 2'b11
  } md_op_t;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } md_state_t;

  function automatic logic is_div(md_op_t op);
    return op[1];
  endfunction
endpackage

// File: rtl/muldiv_if.sv
// muldiv_if: Execute-stage request/result bundle for the sequencer.
// master = Execute side, slave = muldiv_seq.
interface muldiv_if import muldiv_pkg::*; ();
  logic             startE;
  md_op_t           opE;
  logic [WIDTH-1:0] srcAE;
  logic [WIDTH-1:0] srcBE;
  logic             abort;
  logic             StallMD;
  logic             busy;
  logic             result_valid;
  logic [WIDTH-1:0] result;

  modport master (
    output startE, opE, srcAE, srcBE, abort,
    input  StallMD, busy, result_valid, result
  );

  modport slave (
    input  startE, opE, srcAE, srcBE, abort,
    output StallMD, busy, result_valid, result
  );
endinterface

// File: rtl/muldiv_core.sv
// muldiv_core: shift-add multiply / restoring divide datapath.
// One step per 'step' pulse; no control state of its own.
module muldiv_core import muldiv_pkg::*; (
  input  logic             clk,
  input  logic             load,
  input  logic             step,
  input  md_op_t           op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic [WIDTH-1:0] res
);
  md_op_t             op_q;
  logic [WIDTH-1:0]   d_q;
  logic [2*WIDTH-1:0] p_q;
  logic [2*WIDTH-1:0] p_nxt;
  logic               neg_q;
  logic               dz_q;
  logic               sgn;
  logic [WIDTH-1:0]   abs_a;
  logic [WIDTH-1:0]   abs_b;
  logic [WIDTH:0]     add_s;
  logic [WIDTH:0]     rem_sh;
  logic [WIDTH:0]     sub_s;

  assign sgn   = (op == SDIV);
  assign abs_a = (sgn & src_a[WIDTH-1]) ? -src_a : src_a;
  assign abs_b = (sgn & src_b[WIDTH-1]) ? -src_b : src_b;

  // Remainder is < divisor, so the shifted value fits in WIDTH+1 bits
  // and sub_s[WIDTH] is a clean borrow flag.
  always_comb begin
    add_s  = {1'b0, p_q[2*WIDTH-1:WIDTH]}
           + {1'b0, {WIDTH{p_q[0]}} & d_q};
    rem_sh = p_q[2*WIDTH-1:WIDTH-1];
    sub_s  = rem_sh - {1'b0, d_q};
    if (is_div(op_q)) begin
      if (sub_s[WIDTH])
        p_nxt = {rem_sh[WIDTH-1:0], p_q[WIDTH-2:0], 1'b0};
      else
        p_nxt = {sub_s[WIDTH-1:0], p_q[WIDTH-2:0], 1'b1};
    end else begin
      p_nxt = {add_s, p_q[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (load) begin
      op_q  <= op;
      d_q   <= is_div(op) ? abs_b : src_a;
      p_q   <= {{WIDTH{1'b0}}, is_div(op) ? abs_a : src_b};
      neg_q <= sgn & (src_a[WIDTH-1] ^ src_b[WIDTH-1]);
      dz_q  <= is_div(op) & (src_b == '0);
    end else if (step) begin
      p_q <= p_nxt;
    end
  end

  always_comb begin
    res = p_q[WIDTH-1:0];
    if (dz_q) begin
      res = '0;
    end else begin
      case (op_q)
        MULHU:   res = p_q[2*WIDTH-1:WIDTH];
        SDIV:    res = neg_q ? -p_q[WIDTH-1:0] : p_q[WIDTH-1:0];
        default: res = p_q[WIDTH-1:0];
      endcase
    end
  end
endmodule

// File: rtl/muldiv_seq.sv
// muldiv_seq: FSM, step counter, stall and abort control around
// muldiv_core for Execute slot A.
module muldiv_seq import muldiv_pkg::*; (
  input  logic     clk,
  input  logic     reset,
  muldiv_if.slave  md
);
  md_state_t        state_q;
  md_state_t        state_d;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] res_q;
  logic [WIDTH-1:0] core_res;
  logic             take;
  logic             load;
  logic             step;

  assign take = md.startE & ~md.abort;

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    step    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (take) begin
          load = 1'b1;
          if (is_div(md.opE) && md.srcBE == '0)
            state_d = DONE;
          else
            state_d = BUSY;
        end
      end
      BUSY: begin
        step = 1'b1;
        if (cnt_q == CW'(WIDTH-1))
          state_d = DONE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (md.abort) begin
      state_d = IDLE;
      load    = 1'b0;
      step    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      if (load)
        cnt_q <= '0;
      else if (step)
        cnt_q <= cnt_q + 1'b1;
      // Keep the delivered result visible until the next one lands.
      if (state_q == DONE && !md.abort)
        res_q <= core_res;
    end
  end

  muldiv_core u_core (
    .clk   (clk),
    .load  (load),
    .step  (step),
    .op    (md.opE),
    .src_a (md.srcAE),
    .src_b (md.srcBE),
    .res   (core_res)
  );

  assign md.busy         = (state_q == BUSY);
  assign md.result_valid = (state_q == DONE) & ~md.abort;
  assign md.result       = md.result_valid ? core_res : res_q;
  assign md.StallMD      = ((state_q == IDLE) & take)
                         | (state_q == BUSY);
endmodule

// File: tb/tb_muldiv_seq.sv
// tb_muldiv_seq: table vectors, corner sequences and random ops
// checked against an arithmetic reference model.
module tb_muldiv_seq;
  import muldiv_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  muldiv_if bus();

  muldiv_seq dut (
    .clk   (clk),
    .reset (reset),
    .md    (bus.slave)
  );

  int vectors = 0;
  int miscompares = 0;
  logic [31:0] last = '0;

  typedef struct {
    md_op_t      op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl[12];

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_model(md_op_t op, logic [31:0] a,
                                            logic [31:0] b);
    logic [63:0] prod;
    longint sa, sb, q;
    prod = {32'b0, a} * {32'b0, b};
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      MUL:   return prod[31:0];
      MULHU: return prod[63:32];
      UDIV:  return (b == 0) ? 32'd0 : a / b;
      default: begin
        if (b == 0) return 32'd0;
        q = sa / sb;
        return q[31:0];
      end
    endcase
  endfunction

  // Called at a negedge in an IDLE cycle; returns at the negedge after DONE.
  task automatic do_op(string name, md_op_t op, logic [31:0] a,
                       logic [31:0] b, logic [31:0] exp);
    int lat, stalls;
    bit seen, dz;
    logic [31:0] r;
    dz = op[1] && (b == 0);
    bus.opE = op;
    bus.srcAE = a;
    bus.srcBE = b;
    bus.startE = 1'b1;
    #1 check({name, " stall_T"}, 32'(bus.StallMD), 1);
    @(posedge clk);
    #1 bus.startE = 1'b0;
    lat = 0;
    stalls = 1;
    seen = 0;
    r = '0;
    for (int k = 1; k <= 60 && !seen; k++) begin
      @(negedge clk);
      if (bus.StallMD) stalls++;
      if (bus.result_valid) begin
        seen = 1;
        lat = k;
        r = bus.result;
      end
    end
    check({name, " latency"}, lat, dz ? 1 : 33);
    check({name, " stalls"}, stalls, dz ? 1 : 33);
    check({name, " result"}, r, exp);
    @(negedge clk);
    check({name, " strobe_1cyc"}, 32'(bus.result_valid), 0);
    check({name, " hold"}, bus.result, exp);
    last = exp;
  endtask

  initial begin
    int lat;
    bit seen;
    md_op_t op;
    logic [31:0] a, b;

    tbl[0]  = '{MUL,   32'd7,          32'd6,          32'd42};
    tbl[1]  = '{MULHU, 32'hFFFFFFFF,   32'hFFFFFFFF,   32'hFFFFFFFE};
    tbl[2]  = '{MUL,   32'hFFFFFFFF,   32'hFFFFFFFF,   32'h00000001};
    tbl[3]  = '{SDIV,  32'hFFFFFFF9,   32'd2,          32'hFFFFFFFD};
    tbl[4]  = '{SDIV,  32'h80000000,   32'hFFFFFFFF,   32'h80000000};
    tbl[5]  = '{UDIV,  32'd100,        32'd7,          32'd14};
    tbl[6]  = '{UDIV,  32'd5,          32'd0,          32'd0};
    tbl[7]  = '{SDIV,  32'd7,          32'hFFFFFFFE,   32'hFFFFFFFD};
    tbl[8]  = '{SDIV,  32'hFFFFFFF8,   32'd0,          32'd0};
    tbl[9]  = '{MUL,   32'hFFFFFFFD,   32'd5,          32'hFFFFFFF1};
    tbl[10] = '{UDIV,  32'hFFFFFFFF,   32'd1,          32'hFFFFFFFF};
    tbl[11] = '{MULHU, 32'h80000000,   32'd2,          32'd1};

    bus.startE = 1'b0;
    bus.abort = 1'b0;
    bus.opE = MUL;
    bus.srcAE = '0;
    bus.srcBE = '0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst busy", 32'(bus.busy), 0);
    check("rst valid", 32'(bus.result_valid), 0);
    check("rst result", bus.result, 0);
    check("rst stall", 32'(bus.StallMD), 0);
    bus.startE = 1'b1;
    #1 check("rst stall_start", 32'(bus.StallMD), 1);
    bus.startE = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    foreach (tbl[i])
      do_op("tbl", tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].exp);

    // abort and startE together in IDLE
    bus.opE = MUL;
    bus.srcAE = 32'd3;
    bus.srcBE = 32'd3;
    bus.startE = 1'b1;
    bus.abort = 1'b1;
    #1 check("abort_idle stall", 32'(bus.StallMD), 0);
    @(negedge clk);
    check("abort_idle busy", 32'(bus.busy), 0);
    bus.startE = 1'b0;
    bus.abort = 1'b0;

    // abort at T+10 of a divide, new MUL at T+12
    bus.opE = UDIV;
    bus.srcAE = 32'd1000;
    bus.srcBE = 32'd3;
    bus.startE = 1'b1;
    @(posedge clk);
    #1 bus.startE = 1'b0;
    seen = 0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (bus.result_valid) seen = 1;
    end
    bus.abort = 1'b1;
    @(negedge clk);
    if (bus.result_valid) seen = 1;
    check("abort busy", 32'(bus.busy), 0);
    check("abort stall", 32'(bus.StallMD), 0);
    check("abort no_strobe", 32'(seen), 0);
    check("abort result_hold", bus.result, last);
    bus.abort = 1'b0;
    @(negedge clk);
    do_op("after_abort", MUL, 32'd3, 32'd3, 32'd9);

    // reset mid-operation at T+5
    bus.opE = MUL;
    bus.srcAE = 32'h1234;
    bus.srcBE = 32'h5678;
    bus.startE = 1'b1;
    @(posedge clk);
    #1 bus.startE = 1'b0;
    repeat (5) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("midrst busy", 32'(bus.busy), 0);
    check("midrst valid", 32'(bus.result_valid), 0);
    check("midrst result", bus.result, 0);
    check("midrst stall", 32'(bus.StallMD), 0);
    reset = 1'b1;
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.result_valid || bus.busy) seen = 1;
    end
    check("midrst dropped", 32'(seen), 0);
    last = '0;

    // startE held high through BUSY and DONE
    bus.opE = MUL;
    bus.srcAE = 32'd11;
    bus.srcBE = 32'd13;
    bus.startE = 1'b1;
    @(posedge clk);
    lat = 0;
    for (int k = 1; k <= 60 && lat == 0; k++) begin
      @(negedge clk);
      if (bus.result_valid) lat = k;
    end
    check("held latency", lat, 33);
    check("held result", bus.result, 32'd143);
    check("held done_stall", 32'(bus.StallMD), 0);
    @(negedge clk);
    check("held idle_busy", 32'(bus.busy), 0);
    bus.startE = 1'b0;
    @(negedge clk);
    check("held no_restart", 32'(bus.busy), 0);
    last = 32'd143;

    // Random ops against the reference model
    for (int n = 0; n < 30; n++) begin
      op = md_op_t'($urandom_range(0, 3));
      a = $urandom;
      b = $urandom;
      if ($urandom_range(0, 3) == 0) b = $urandom_range(1, 20);
      if ($urandom_range(0, 7) == 0) b = '0;
      do_op("rand", op, a, b, ref_model(op, a, b));
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/muldiv_seq.md
# muldiv_seq

Iterative multiply/divide sequencer for the Execute stage of the dual-issue pipeline. Accepts one MUL/MULHU/UDIV/SDIV operation from Execute issue slot A, runs a 32-step shift-add or restoring-divide datapath, and holds the front of the pipeline with stall requests until the result is ready. The result is handed back on a one-cycle valid strobe, which the Execute-stage result mux selects in place of the ALU output.

## Interface
- WIDTH, 32: operand and result width; iteration count equals WIDTH.
- clk  in  1  pipeline clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-low reset (0 = reset).
- startE  in  1  slot-A instruction in Execute is a mul/div op.
- opE  in  2  00 MUL (low word), 01 MULHU (unsigned high word), 10 UDIV, 11 SDIV.
- srcAE, srcBE  in  WIDTH  forwarded operands (dividend/multiplicand, divisor/multiplier).
- abort  in  1  cancel any in-flight operation (exception/flush).
- StallMD  out  1  OR'd into StallF, StallD and the Execute hold enable.
- busy  out  1  state is BUSY.
- result_valid  out  1  one-cycle strobe; result is valid.
- result  out  WIDTH  operation result.

## Operation
- States: IDLE, BUSY, DONE.
- IDLE
  - With startE=1 and abort=0: latch opE and operands, clear the counter.
  - Next state is DONE if the op is a divide with srcBE==0; otherwise BUSY.
- BUSY
  - One datapath step per cycle; the counter increments 0..WIDTH-1.
  - At count==WIDTH-1, next state is DONE.
- DONE
  - result_valid=1 and result is driven.
  - startE is ignored (the same instruction is still in Execute); next state is IDLE.
- abort=1 in any state: next state is IDLE, no result_valid is produced, and latched data is discarded.
- StallMD is combinational: (IDLE & startE & ~abort) | BUSY. It is 0 in DONE, so the instruction leaves Execute with its result.
- MUL and MULHU
  - Unsigned 2·WIDTH product via shift-add, LSB of the multiplier first.
  - MUL returns bits [WIDTH-1:0]; MULHU returns bits [2·WIDTH-1:WIDTH].
  - MUL is correct for signed operands as well.
- UDIV: restoring division, MSB first, producing the quotient. The remainder is discarded.
- SDIV
  - Divide the magnitudes; negate the quotient if the operand signs differ. Result truncates toward zero.
  - 0x80000000 / 0xFFFFFFFF yields 0x80000000 (wraps, no trap).
- Divide by zero (UDIV or SDIV): result 0, using the fast path IDLE→DONE.
- All arithmetic is modulo 2^WIDTH; there are no overflow flags.

## Timing
- Start sampled in cycle T
  - T+1..T+WIDTH: BUSY.
  - T+WIDTH+1: DONE, result_valid=1.
  - StallMD high in cycles T..T+WIDTH (WIDTH+1 cycles).
- Divide by zero: DONE at T+1; StallMD high only in T.
- Back-to-back ops: the next startE is accepted in the IDLE cycle after DONE, so there is a minimum of one idle cycle between operations.
- Outputs on reset (reset=0 at an edge)
  - state IDLE.
  - busy=0, result_valid=0, result=0, counter=0.
  - StallMD=0 unless startE is asserted that cycle.
  - Reset mid-BUSY drops the operation with no strobe.
- abort and startE both high in IDLE: abort wins and StallMD=0.
- result holds its value after DONE until the next operation completes.

## Structure
- Package muldiv_pkg holds:
  - the md_op_t enum (MUL, MULHU, UDIV, SDIV);
  - the md_state_t enum (IDLE, BUSY, DONE);
  - localparam WIDTH=32.
- Sub-module muldiv_core holds the datapath:
  - 2·WIDTH product/remainder shift register, operand registers, sign fixup.
  - Control inputs load, step, op. It has no FSM.
- muldiv_seq keeps the FSM, counter, stall and abort logic, and instantiates muldiv_core.

## Test plan
- MUL 7×6 started at T → StallMD high T..T+32, result_valid at T+33 with result 42, then IDLE.
- MULHU 0xFFFFFFFF×0xFFFFFFFF → result 0xFFFFFFFE; MUL of the same operands → 0x00000001.
- SDIV −7/2 → 0xFFFFFFFD (−3); SDIV 0x80000000/−1 → 0x80000000; UDIV 100/7 → 14.
- UDIV 5/0 → result_valid at T+1 with result 0; StallMD high only in T.
- abort at T+10 of a divide → IDLE at T+11, StallMD=0, no result_valid; a new MUL 3×3 at T+12 → 9 at T+45.
- reset=0 at T+5 mid-operation → busy=0, result_valid=0, result=0 after the edge; startE held high through DONE does not restart the op.
